// File: rtl/uart_tx_if.sv
// Host-side byte interface of the UART transmitter.
// The host (master) drives start/data; the transmitter (slave) drives the serial line and status.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Each bit is held CLKS_PER_BIT clocks; a start during the tx_done cycle chains the next frame.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);

  localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam bit            ONE_CLK   = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_tx;
  logic            r_done;

  logic            w_tick;
  logic            w_stop_pre;

  assign w_tick     = (r_baud == BAUD_LAST);
  // Second-to-last STOP clock: tx_done is registered, so it is armed one clock early.
  assign w_stop_pre = !ONE_CLK && (r_baud == BAUD_PRE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_tick ? '0 : r_baud + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (bus.tx_start) begin
            r_shift <= bus.tx_data;
            r_par   <= 1'b0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_par   <= r_par ^ r_shift[0];
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              if (PARITY_EN) begin
                r_tx    <= r_par ^ r_shift[0];
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_done  <= ONE_CLK;
                r_state <= S_STOP;
              end
            end else begin
              r_tx <= r_shift[1];
            end
          end
        end

        S_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_done  <= ONE_CLK;
            r_state <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            if (bus.tx_start) begin
              r_shift <= bus.tx_data;
              r_par   <= 1'b0;
              r_bit   <= '0;
              r_baud  <= '0;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_done <= w_stop_pre;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx      = r_tx;
  assign bus.tx_busy = (r_state != S_IDLE);
  assign bus.tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 clk/bit no parity, 4 clk/bit with parity) checked
// cycle by cycle against a frame model derived from bit positions in the frame.
module tb_uart_tx;

  logic clk;
  logic rst;

  uart_tx_if a_if ();
  uart_tx_if b_if ();

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned cpb_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit par_of(int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic int unsigned flen(int d);
    return (10 + (par_of(d) ? 1 : 0)) * cpb_of(d);
  endfunction

  // Expected line level in cycle c (1-based, counted from the accept edge).
  function automatic logic exp_tx(logic [7:0] b, int unsigned cpb, bit par, int unsigned c);
    int unsigned k;
    k = (c - 1) / cpb;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [2:0] obs(int d);
    return (d == 0) ? {a_if.tx, a_if.tx_busy, a_if.tx_done}
                    : {b_if.tx, b_if.tx_busy, b_if.tx_done};
  endfunction

  task automatic drive(int d, logic s, logic [7:0] v);
    if (d == 0) begin
      a_if.tx_start = s;
      a_if.tx_data  = v;
    end else begin
      b_if.tx_start = s;
      b_if.tx_data  = v;
    end
  endtask

  // Serial decoder on instance A for the loopback scenario.
  logic [7:0]  lb_q[$];
  bit          lb_en = 1'b0;
  int unsigned lb_cnt = 0;
  int unsigned lb_rx = 0;
  logic [7:0]  lb_byte;
  logic [7:0]  lb_exp;

  always @(negedge clk) begin
    if (lb_en && !rst) begin
      if (lb_cnt == 0) begin
        if (a_if.tx == 1'b0) lb_cnt = 1;
      end else if (lb_cnt <= 8) begin
        lb_byte[lb_cnt-1] = a_if.tx;
        lb_cnt++;
      end else begin
        n_vec++;
        lb_exp = (lb_q.size() > 0) ? lb_q.pop_front() : 8'hxx;
        if ({a_if.tx, lb_byte} !== {1'b1, lb_exp}) begin
          n_err++;
          $display("FAIL loopback byte %0d: got stop=%b data=%h, want stop=1 data=%h",
                   lb_rx, a_if.tx, lb_byte, lb_exp);
        end
        lb_rx++;
        lb_cnt = 0;
      end
    end
  end

  task automatic test_reset;
    logic [2:0] o;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 8'h00);
    drive(1, 1'b1, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      n_vec++;
      if (o !== 3'b010) begin
        n_err++;
        $display("FAIL reset_preframe dut%0d: got {tx,busy,done}=%b want 010", d, o);
      end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      n_vec++;
      if (o !== 3'b100) begin
        n_err++;
        $display("FAIL reset_async dut%0d: got {tx,busy,done}=%b want 100", d, o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o = obs(d);
        n_vec++;
        if (o !== 3'b100) begin
          n_err++;
          $display("FAIL reset_hold dut%0d cyc%0d: got {tx,busy,done}=%b want 100", d, i, o);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte(int d, logic [7:0] b);
    logic [2:0]  o;
    logic [2:0]  e;
    int unsigned f;
    f = flen(d);
    @(negedge clk);
    drive(d, 1'b1, b);
    @(posedge clk);
    #1 drive(d, 1'b0, ~b);
    for (int unsigned c = 1; c <= f; c++) begin
      @(negedge clk);
      o = obs(d);
      e = {exp_tx(b, cpb_of(d), par_of(d), c), 1'b1, (c == f)};
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL frame dut%0d byte %h cyc E+%0d: got {tx,busy,done}=%b want %b", d, b, c, o, e);
      end
    end
    @(negedge clk);
    o = obs(d);
    n_vec++;
    if (o !== 3'b100) begin
      n_err++;
      $display("FAIL frame_idle dut%0d byte %h: got {tx,busy,done}=%b want 100", d, b, o);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      test_single_byte(i % 2, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o;
    logic [2:0]  e;
    logic [7:0]  bytes [2];
    int unsigned f;
    bytes[0] = 8'h3C;
    bytes[1] = 8'hC3;
    f = flen(1);
    @(negedge clk);
    drive(1, 1'b1, bytes[0]);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    for (int fr = 0; fr < 2; fr++) begin
      for (int unsigned c = 1; c <= f; c++) begin
        if (c > 1) @(negedge clk);
        if (c == 1 && fr == 1) drive(1, 1'b0, 8'h00);
        if (c == 21 && fr == 0) drive(1, 1'b0, 8'h00);
        o = obs(1);
        e = {exp_tx(bytes[fr], 4, 1'b1, c), 1'b1, (c == f)};
        n_vec++;
        if (o !== e) begin
          n_err++;
          $display("FAIL back_to_back frame%0d cyc E+%0d: got {tx,busy,done}=%b want %b", fr, c, o, e);
        end
        if (c == 20 && fr == 0) drive(1, 1'b1, 8'hFF);
        if (c == f && fr == 0) drive(1, 1'b1, bytes[1]);
      end
      @(negedge clk);
    end
    o = obs(1);
    n_vec++;
    if (o !== 3'b100) begin
      n_err++;
      $display("FAIL back_to_back_idle: got {tx,busy,done}=%b want 100", o);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [2:0] o;
    @(negedge clk);
    drive(1, 1'b1, 8'h00);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    repeat (17) @(negedge clk);
    o = obs(1);
    n_vec++;
    if (o !== 3'b010) begin
      n_err++;
      $display("FAIL midrst_bit3: got {tx,busy,done}=%b want 010", o);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 o = obs(1);
    n_vec++;
    if (o !== 3'b100) begin
      n_err++;
      $display("FAIL midrst_async: got {tx,busy,done}=%b want 100", o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      o = obs(1);
      n_vec++;
      if (o !== 3'b100) begin
        n_err++;
        $display("FAIL midrst_after cyc%0d: got {tx,busy,done}=%b want 100", i, o);
      end
    end
    test_single_byte(1, 8'h81);
  endtask

  task automatic test_loopback;
    logic [7:0] b;
    bit         seen;
    lb_q.delete();
    lb_cnt = 0;
    lb_rx  = 0;
    lb_en  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      lb_q.push_back(b);
      if (i > 0) begin
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
          @(negedge clk);
          seen = a_if.tx_done;
        end
        if (!seen) begin
          n_vec++;
          n_err++;
          $display("FAIL loopback_done_timeout byte %0d: got no tx_done in 20 cycles, want one", i);
        end
      end
      drive(0, 1'b1, b);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
    end
    repeat (14) @(negedge clk);
    lb_en = 1'b0;
    n_vec++;
    if (lb_rx != 256 || lb_q.size() != 0) begin
      n_err++;
      $display("FAIL loopback_count: got %0d bytes (%0d left), want 256 (0 left)", lb_rx, lb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    test_reset();
    test_single_byte(0, 8'hA5);
    test_single_byte(1, 8'h07);
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
